// File: rtl/axi_lite_pkg.sv
`default_nettype none
// =============================================================================
// Module  : axi_lite_pkg
// Brief   : Response codes and FSM state encodings shared by AXI4-Lite slaves.
// Rev     : 1.0  initial release
// =============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned WR_STATE_W = 1;
    localparam logic [WR_STATE_W-1:0] WR_IDLE = 1'b0;
    localparam logic [WR_STATE_W-1:0] WR_RESP = 1'b1;

    localparam int unsigned RD_STATE_W = 1;
    localparam logic [RD_STATE_W-1:0] RD_IDLE = 1'b0;
    localparam logic [RD_STATE_W-1:0] RD_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/axi_lite_wr_capture.sv
`default_nettype none
// =============================================================================
// Module  : axi_lite_wr_capture
// Brief   : Independent AW/W capture with got-flags; emits a one-cycle commit.
// Rev     : 1.0  initial release
// =============================================================================
module axi_lite_wr_capture #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    input  logic              i_release,
    output logic              o_commit,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [STRB_W-1:0] o_strb
);
    logic              aw_got_q, aw_got_d;
    logic              w_got_q, w_got_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [STRB_W-1:0] strb_q, strb_d;
    logic              w_aw_hs;
    logic              w_w_hs;

    assign w_aw_hs = i_awvalid & awready_q;
    assign w_w_hs  = i_wvalid & wready_q;

    // Flags stay set through the response phase, which also holds both readies low.
    always_comb begin
        aw_got_d = aw_got_q | w_aw_hs;
        w_got_d  = w_got_q | w_w_hs;
        addr_d   = w_aw_hs ? i_awaddr : addr_q;
        data_d   = w_w_hs ? i_wdata : data_q;
        strb_d   = w_w_hs ? i_wstrb : strb_q;
        if (i_release) begin
            aw_got_d = 1'b0;
            w_got_d  = 1'b0;
        end
        awready_d = ~aw_got_d;
        wready_d  = ~w_got_d;
        o_commit  = (aw_got_q | w_aw_hs) & (w_got_q | w_w_hs) & ~(aw_got_q & w_got_q);
        o_addr    = addr_d;
        o_data    = data_d;
        o_strb    = strb_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

    assign o_awready = awready_q;
    assign o_wready  = wready_q;

endmodule
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// =============================================================================
// Module  : axi_lite_regfile
// Brief   : AXI4-Lite register file with byte strobes and SLVERR on bad index.
// Rev     : 1.0  initial release
// =============================================================================
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int                 DATA_W   = 32,
    parameter int                 ADDR_W   = 6,
    parameter int                 NUM_REGS = 16,
    parameter logic [DATA_W-1:0]  INIT0    = 32'hAAAAAAAA,
    parameter logic [DATA_W-1:0]  INIT1    = 32'h55555555
) (
    input  logic                       axi_aclk,
    input  logic                       axi_aresetn,
    input  logic [ADDR_W-1:0]          axi_awaddr,
    input  logic                       axi_awvalid,
    output logic                       axi_awready,
    input  logic [DATA_W-1:0]          axi_wdata,
    input  logic [DATA_W/8-1:0]        axi_wstrb,
    input  logic                       axi_wvalid,
    output logic                       axi_wready,
    output logic [1:0]                 axi_bresp,
    output logic                       axi_bvalid,
    input  logic                       axi_bready,
    input  logic [ADDR_W-1:0]          axi_araddr,
    input  logic                       axi_arvalid,
    output logic                       axi_arready,
    output logic [DATA_W-1:0]          axi_rdata,
    output logic [1:0]                 axi_rresp,
    output logic                       axi_rvalid,
    input  logic                       axi_rready,
    output logic [NUM_REGS*DATA_W-1:0] regs_o
);
    localparam int          STRB_W     = DATA_W / 8;
    localparam int          IDX_W      = ADDR_W - 2;
    localparam logic [31:0] NUM_REGS_U = NUM_REGS;

    function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_v,
                                                     input logic [DATA_W-1:0] new_v,
                                                     input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] v;
        v = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] init_value(input int idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx == 0) v = INIT0;
        if (idx == 1) v = INIT1;
        return v;
    endfunction

    logic                  w_commit;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [DATA_W-1:0]     w_wr_data;
    logic [STRB_W-1:0]     w_wr_strb;
    logic [IDX_W-1:0]      w_wr_idx;
    logic                  w_wr_in_range;
    logic                  w_release;
    logic [WR_STATE_W-1:0] wr_state_q, wr_state_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [RD_STATE_W-1:0] rd_state_q, rd_state_d;
    logic                  arready_q, arready_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  w_ar_hs;
    logic [IDX_W-1:0]      w_rd_idx;
    logic                  w_rd_in_range;
    logic [DATA_W-1:0]     w_rd_word;
    logic                  w_unused_addr_bits;

    assign w_unused_addr_bits = ^{w_wr_addr[1:0], axi_araddr[1:0]};

    axi_lite_wr_capture #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_wr_capture (
        .clk       (axi_aclk),
        .rst_n     (axi_aresetn),
        .i_awaddr  (axi_awaddr),
        .i_awvalid (axi_awvalid),
        .o_awready (axi_awready),
        .i_wdata   (axi_wdata),
        .i_wstrb   (axi_wstrb),
        .i_wvalid  (axi_wvalid),
        .o_wready  (axi_wready),
        .i_release (w_release),
        .o_commit  (w_commit),
        .o_addr    (w_wr_addr),
        .o_data    (w_wr_data),
        .o_strb    (w_wr_strb)
    );

    assign w_wr_idx      = w_wr_addr[ADDR_W-1:2];
    assign w_wr_in_range = (32'(w_wr_idx) < NUM_REGS_U);
    assign w_release     = (wr_state_q == WR_RESP) & axi_bready;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] reg_q, reg_d;
        logic              w_hit;
        assign w_hit = w_commit & w_wr_in_range & (w_wr_idx == IDX_W'(gi));
        always_comb begin
            reg_d = reg_q;
            if (w_hit) reg_d = strb_merge(reg_q, w_wr_data, w_wr_strb);
        end
        always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
            if (!axi_aresetn) reg_q <= init_value(gi);
            else              reg_q <= reg_d;
        end
        assign regs_o[gi*DATA_W +: DATA_W] = reg_q;
    end

    // Write response FSM
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_state_q <= WR_IDLE;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            bresp_q    <= bresp_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (w_commit) begin
                    wr_state_d = WR_RESP;
                    bresp_d    = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            WR_RESP: if (axi_bready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        axi_bvalid = (wr_state_q == WR_RESP);
    end

    assign axi_bresp = bresp_q;

    // Read FSM; the read samples pre-commit contents so a colliding write is not visible.
    assign w_ar_hs       = axi_arvalid & arready_q;
    assign w_rd_idx      = axi_araddr[ADDR_W-1:2];
    assign w_rd_in_range = (32'(w_rd_idx) < NUM_REGS_U);

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_rd_idx == IDX_W'(i)) w_rd_word = regs_o[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    rd_state_d = RD_DATA;
                    rdata_d    = w_rd_in_range ? w_rd_word : '0;
                    rresp_d    = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            RD_DATA: if (axi_rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
        arready_d = (rd_state_d == RD_IDLE);
    end

    always_comb begin
        axi_rvalid = (rd_state_q == RD_DATA);
    end

    assign axi_arready = arready_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// =============================================================================
// Module  : tb_axi_lite_regfile
// Brief   : Randomised self-checking bench with an array reference model.
// Rev     : 1.0  initial release
// =============================================================================
module tb_axi_lite_regfile;
    localparam int          AW    = 7;
    localparam int          NR    = 15;
    localparam int          RW    = NR * 32;
    localparam logic [31:0] INIT0 = 32'hAAAAAAAA;
    localparam logic [31:0] INIT1 = 32'h55555555;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          awready, wready, bvalid, arready, rvalid;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata;
    logic [RW-1:0] regs;

    logic [31:0] model [NR];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_lite_regfile #(
        .DATA_W   (32),
        .ADDR_W   (AW),
        .NUM_REGS (NR),
        .INIT0    (INIT0),
        .INIT1    (INIT1)
    ) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .axi_awaddr  (awaddr),
        .axi_awvalid (awvalid),
        .axi_awready (awready),
        .axi_wdata   (wdata),
        .axi_wstrb   (wstrb),
        .axi_wvalid  (wvalid),
        .axi_wready  (wready),
        .axi_bresp   (bresp),
        .axi_bvalid  (bvalid),
        .axi_bready  (bready),
        .axi_araddr  (araddr),
        .axi_arvalid (arvalid),
        .axi_arready (arready),
        .axi_rdata   (rdata),
        .axi_rresp   (rresp),
        .axi_rvalid  (rvalid),
        .axi_rready  (rready),
        .regs_o      (regs)
    );

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        model[0] = INIT0;
        model[1] = INIT1;
    endtask

    function automatic logic [RW-1:0] model_flat();
        logic [RW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[i];
        return v;
    endfunction

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int          idx;
        logic [1:0]  exp_resp;
        bready = 1'b0;
        fork
            begin
                int n;
                repeat (aw_dly) @(posedge clk);
                #1;
                awaddr = addr; awvalid = 1'b1; n = 0;
                while (!awready && n < 20) begin @(posedge clk); #1; n++; end
                check("awready_wait", awready, 1);
                @(posedge clk); #1;
                awvalid = 1'b0; awaddr = AW'($urandom);
            end
            begin
                int n;
                repeat (w_dly) @(posedge clk);
                #1;
                wdata = data; wstrb = strb; wvalid = 1'b1; n = 0;
                while (!wready && n < 20) begin @(posedge clk); #1; n++; end
                check("wready_wait", wready, 1);
                @(posedge clk); #1;
                wvalid = 1'b0; wdata = $urandom; wstrb = 4'($urandom);
            end
        join
        idx = int'(addr[AW-1:2]);
        exp_resp = (idx < NR) ? 2'b00 : 2'b10;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        check("bvalid_latency", bvalid, 1);
        check("bresp", bresp, exp_resp);
        check("regs_after_write", regs, model_flat());
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); #1;
            check("bvalid_hold", bvalid, 1);
            check("bresp_hold", bresp, exp_resp);
            check("ready_hold", {awready, wready}, 2'b00);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int r_dly, input bit poke_ar);
        int          n, idx;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        rready = 1'b0;
        araddr = addr; arvalid = 1'b1; n = 0;
        while (!arready && n < 20) begin @(posedge clk); #1; n++; end
        check("arready_wait", arready, 1);
        idx   = int'(addr[AW-1:2]);
        exp_d = (idx < NR) ? model[idx] : 32'h0;
        exp_r = (idx < NR) ? 2'b00 : 2'b10;
        @(posedge clk); #1;
        arvalid = 1'b0; araddr = AW'($urandom);
        check("rvalid_latency", rvalid, 1);
        check("rdata", rdata, exp_d);
        check("rresp", rresp, exp_r);
        for (int k = 0; k < r_dly; k++) begin
            if (poke_ar) begin arvalid = 1'b1; araddr = AW'($urandom); end
            @(posedge clk); #1;
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, exp_d);
            check("rresp_hold", rresp, exp_r);
            check("arready_hold", arready, 0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_readies", {awready, wready, arready}, 3'b000);
        check("rst_resps", {bresp, rresp}, 4'b0000);
        check("rst_rdata", rdata, 0);
        check("rst_regs", regs, model_flat());
        rst_n = 1'b1;
        #1;
        check("readies_before_edge", {awready, wready, arready}, 3'b000);
        @(posedge clk); #1;
        check("readies_first_edge", {awready, wready, arready}, 3'b111);

        do_read(7'h00, 0, 1'b0);
        do_read(7'h04, 0, 1'b0);
        do_read(7'h08, 0, 1'b0);

        do_write(7'h08, 32'h12345678, 4'hF, 2, 0, 0);
        check("reg2_slice", regs[2*32 +: 32], 32'h12345678);
        do_read(7'h08, 0, 1'b0);

        do_write(7'h0C, 32'hFFFFFFFF, 4'b0101, 0, 0, 0);
        check("reg3_strobe_merge", regs[3*32 +: 32], 32'h00FF00FF);
        do_read(7'h0F, 0, 1'b0);

        do_write(7'h40, 32'hCAFEF00D, 4'hF, 0, 1, 0);
        do_read(7'h3C, 0, 1'b0);
        do_write(7'h14, 32'h9ABCDEF0, 4'h0, 1, 0, 0);

        do_write(7'h18, 32'h0F0F1234, 4'hF, 0, 0, 5);
        do_read(7'h18, 5, 1'b1);

        // Write commit and AR handshake on the same edge to the same register.
        fork
            do_write(7'h14, 32'h77778888, 4'hF, 0, 0, 0);
            do_read(7'h14, 0, 1'b0);
        join
        do_read(7'h14, 0, 1'b0);

        // Reset while a write response is pending.
        awaddr = 7'h04; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("rst_case_bvalid", bvalid, 1);
        check("rst_case_reg1", regs[1*32 +: 32], 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_bvalid", bvalid, 0);
        check("rst_async_readies", {awready, wready, arready}, 3'b000);
        check("rst_async_reg1", regs[1*32 +: 32], INIT1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst2_readies", {awready, wready, arready}, 3'b111);

        // A half-captured write must be discarded by reset.
        wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("partial_wready_low", wready, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_write(7'h08, 32'h11112222, 4'hF, 0, 0, 0);
        do_read(7'h04, 0, 1'b0);

        for (int t = 0; t < 80; t++) begin
            logic [AW-1:0] a;
            a = AW'($urandom_range(0, 8'h4F));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 2));
            else
                do_read(a, $urandom_range(0, 2), 1'($urandom));
        end
        check("final_regs", regs, model_flat());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
